return_address_stack: RTL
=========================

# return_address_stack

Return-address predictor that consumes the link value produced by the program counter on call instructions and supplies it back as the jump target on return instructions. It is a fixed-depth circular LIFO beside the program counter in the fetch stage. The fetch/decode control asserts `push` on a jump-and-link and `pop` on a return; `top` feeds the jump-target mux. Overflow silently discards the oldest entry, matching hardware RAS practice.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `WIDTH`, 32: address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  empties the stack, e.g. on an exception or pipeline redirect.
- `push`  in  1  pushes `push_addr` (the PC link value).
- `push_addr`  in  WIDTH  return address to store.
- `pop`  in  1  consumes the top entry.
- `top`  out  WIDTH  current top entry; 0 when empty.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `count`  out  $clog2(DEPTH+1)  number of valid entries.
- `overflow`  out  1  one-cycle pulse: the previous cycle pushed while full.
- `underflow`  out  1  one-cycle pulse: the previous cycle popped while empty.

## Operation
- State:
  - storage `mem[DEPTH]`;
  - top pointer `tp`, $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - `count`;
  - `overflow` and `underflow` registers.
- Output derivation: `top = (count != 0) ? mem[tp] : 0`, combinational from registered state. `empty` and `full` derive from `count`.
- Priority: `reset` > `flush` > push/pop.
- `reset`: `tp = 0`, `count = 0`, `overflow = 0`, `underflow = 0`. Memory contents are don't-care.
- `flush`: same as `reset` for `tp`, `count` and both flags. Push and pop in the same cycle are ignored.
- `push` only, not full: `tp <= tp+1`, `mem[tp+1] <= push_addr`, `count <= count+1`.
- `push` only, full:
  - `tp <= tp+1` and `mem[tp+1] <= push_addr`, overwriting the oldest entry;
  - `count` stays at DEPTH;
  - `overflow <= 1`.
- `pop` only, not empty: `tp <= tp-1` with wrap from 0 to DEPTH-1; `count <= count-1`.
- `pop` only, empty: no state change; `underflow <= 1`.
- `push` and `pop` together, not empty: `mem[tp] <= push_addr`. `tp` and `count` are unchanged. This is a tail-call or return-then-call; no flag is raised.
- `push` and `pop` together, empty: treated as a push only (`count` becomes 1); no flags.
- `overflow` and `underflow` are 0 in every cycle not listed above.

## Timing
- Zero-latency read: `top` reflects the state after the last edge. A `pop` consumes the current `top` in the same cycle it is asserted.
- A value pushed at edge N appears on `top` after edge N and is usable in cycle N+1.
- Back-to-back push/pop every cycle is supported; no stalls and no ready signal.
- Flags are registered and go high in the cycle after the offending request.
- `reset` or `flush` mid-sequence: the next cycle shows `empty=1`, `top=0`, `count=0`, and both flags 0.
- Pointer wrap: `tp` wraps from DEPTH-1 to 0 on push and from 0 to DEPTH-1 on pop, with no special casing.

## Structure
- Shared package holds the `XLEN = 32` constant, used as the `WIDTH` default and by the program counter.
- Natural sub-module: `ras_pointer`, which owns `tp` and `count` and implements the increment, decrement, saturation and wrap logic, along with the overflow and underflow flags.
- The top level holds the storage array, the write-address mux (`tp+1` vs `tp`) and the `top` read mux.

## Test plan
All scenarios use DEPTH=4.
- Reset, then idle → `empty=1`, `top=0`, `count=0`, both flags 0.
- Push 0x100, 0x200, 0x300 → `count=3`, `top=0x300`. Then pop 3× → `top` reads 0x200, 0x100, then 0, and `empty=1` after the last pop.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 → 5th push gives `overflow=1` for one cycle, `count=4`, `top=0x50`. Then pop 4× → `top` reads 0x40, 0x30, 0x20, then `empty`; 0x10 is lost.
- Pop while empty → `underflow=1` for exactly one cycle; `count` and `top` unchanged.
- Push 0x100, then push 0x200 with pop in the same cycle → `count=1`, `top=0x200`. Push+pop while empty with 0x300 → `count=1`, `top=0x300`.
- Push 0xA0 and 0xB0; then assert `flush` together with `push` of 0xC0 → `empty=1`, `top=0`. Repeat the pushes, then assert `reset` together with `pop` → `empty=1`, no `underflow`.

Source files
------------

// File: rtl/return_address_stack_pkg.sv
// Shared constants for the fetch-stage return-address predictor.
// XLEN is the machine address width, shared with the program counter.
package return_address_stack_pkg;
  localparam int XLEN = 32;
endpackage

// File: rtl/return_address_stack_pointer.sv
// ras_pointer: owns the circular top pointer, the occupancy count,
// and the registered overflow/underflow pulses of the return-address stack.
module ras_pointer #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [PW-1:0] tp,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // DEPTH is a power of two, so plain PW-bit arithmetic gives the wrap.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (push && pop && !empty) begin
        // Replace-in-place: the top entry is overwritten by the top level.
      end else if (push) begin
        tp <= tp + 1'b1;
        if (full) overflow <= 1'b1;
        else      count    <= count + 1'b1;
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          tp    <= tp - 1'b1;
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/return_address_stack.sv
// Fixed-depth circular LIFO of return addresses: push on call, pop on return.
// No handshake: push/pop are accepted every cycle; overflow drops the oldest entry.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_addr,
  input  logic                       pop,
  output logic [WIDTH-1:0]           top,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tp;
  logic [PW-1:0]    wr_addr;
  logic             wr_en;

  ras_pointer #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .tp        (tp),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Push+pop on a non-empty stack rewrites the current top; otherwise a push
  // lands one slot above it (an empty push+pop behaves as a plain push).
  assign wr_en   = push && !reset && !flush;
  assign wr_addr = (pop && !empty) ? tp : tp + 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= push_addr;
  end

  assign top = empty ? '0 : mem[tp];

endmodule
